// File: rtl/cordic_rotate_iter_pkg.sv
// Shared types and constants for the rotation-mode CORDIC.
// Holds the arctangent table, the iteration limit and the FSM state type.
package cordic_pkg;

  localparam int ITERS_MAX = 14;

  typedef enum logic [1:0] {
    IDLE,
    ROT,
    SCALE
  } state_t;

  // atan(2^-i) in units of 2^-16 turn
  function automatic logic [15:0] atan_f(input logic [3:0] i);
    logic [15:0] r;
    r = 16'd0;
    case (i)
      4'd0:  r = 16'd8192;
      4'd1:  r = 16'd4836;
      4'd2:  r = 16'd2555;
      4'd3:  r = 16'd1297;
      4'd4:  r = 16'd651;
      4'd5:  r = 16'd326;
      4'd6:  r = 16'd163;
      4'd7:  r = 16'd81;
      4'd8:  r = 16'd41;
      4'd9:  r = 16'd20;
      4'd10: r = 16'd10;
      4'd11: r = 16'd5;
      4'd12: r = 16'd3;
      4'd13: r = 16'd1;
      default: r = 16'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cordic_rotate_iter_gain_sat.sv
// CORDIC gain compensation (x0.6074 by shift-add) and saturation.
// Ports: v_i wide signed datapath value, q_o WIDTH-bit signed result.
module cordic_gain_sat #(
  parameter int WIDTH = 16,
  parameter int GUARD = 2
) (
  input  logic [WIDTH+GUARD-1:0] v_i,
  output logic [WIDTH-1:0]       q_o
);

  localparam int DW = WIDTH + GUARD;
  localparam int SW = DW + 1;

  logic signed [SW-1:0] ve;
  logic signed [SW-1:0] p;
  logic                 ovf;

  assign ve = $signed({v_i[DW-1], v_i});
  assign p  = (ve >>> 1) + (ve >>> 3)
            - (ve >>> 6) - (ve >>> 9);

  // overflow when the bits above the result sign disagree with it
  assign ovf = p[SW-1:WIDTH-1]
            != {(SW-WIDTH+1){p[SW-1]}};

  always_comb begin
    q_o = p[WIDTH-1:0];
    if (ovf) begin
      q_o = p[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                    : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/cordic_rotate_iter.sv
// Iterative rotation-mode CORDIC: (mag*cos a, mag*sin a), one step/clk.
// Ports: clk, rst_n, start, angle_in, mag_in -> busy, done, cos_out, sin_out.
module cordic_rotate_iter
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITERS = 14,
  parameter int GUARD = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      angle_in,
  input  logic [WIDTH-1:0] mag_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] cos_out,
  output logic [WIDTH-1:0] sin_out
);

  localparam int DW = WIDTH + GUARD;

  state_t               state_q;
  logic signed [DW-1:0] x_q, y_q;
  logic signed [DW-1:0] x_sh, y_sh;
  logic signed [DW-1:0] mag_ext;
  logic signed [15:0]   z_q;
  logic signed [15:0]   atan_v;
  logic [3:0]           i_q;
  logic                 busy_q, done_q;
  logic [WIDTH-1:0]     cos_q, sin_q;
  logic [WIDTH-1:0]     cos_d, sin_d;
  logic                 fold;

  assign mag_ext = $signed({{GUARD{mag_in[WIDTH-1]}}, mag_in});
  // angles in 90..270 deg are pre-rotated by 180 deg
  assign fold    = angle_in[15] ^ angle_in[14];
  assign x_sh    = x_q >>> i_q;
  assign y_sh    = y_q >>> i_q;
  assign atan_v  = $signed(atan_f(i_q));

  cordic_gain_sat #(
    .WIDTH(WIDTH),
    .GUARD(GUARD)
  ) u_gain_x (
    .v_i(x_q),
    .q_o(cos_d)
  );

  cordic_gain_sat #(
    .WIDTH(WIDTH),
    .GUARD(GUARD)
  ) u_gain_y (
    .v_i(y_q),
    .q_o(sin_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cos_q   <= '0;
      sin_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ROT;
            busy_q  <= 1'b1;
            y_q     <= '0;
            i_q     <= '0;
            if (fold) begin
              x_q <= -mag_ext;
              z_q <= $signed(angle_in - 16'h8000);
            end else begin
              x_q <= mag_ext;
              z_q <= $signed(angle_in);
            end
          end
        end
        ROT: begin
          if (!z_q[15]) begin
            x_q <= x_q - y_sh;
            y_q <= y_q + x_sh;
            z_q <= z_q - atan_v;
          end else begin
            x_q <= x_q + y_sh;
            y_q <= y_q - x_sh;
            z_q <= z_q + atan_v;
          end
          i_q <= i_q + 4'd1;
          if (i_q == 4'(ITERS - 1)) begin
            state_q <= SCALE;
          end
        end
        SCALE: begin
          cos_q   <= cos_d;
          sin_q   <= sin_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign cos_out = cos_q;
  assign sin_out = sin_q;

endmodule

// File: tb/tb_cordic_rotate_iter.sv
// Self-checking bench for cordic_rotate_iter.
// Reference: real-valued rotation scaled by the ideal CORDIC gain product.
module tb_cordic_rotate_iter;

  localparam int  N    = 14;
  localparam real PI   = 3.14159265358979;
  localparam int  TOLS = 6;
  localparam int  TOLL = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] angle_in = '0;
  logic [15:0] mag_in = '0;
  logic        busy, done;
  logic [15:0] cos_out, sin_out;

  int  n_chk = 0;
  int  n_fail = 0;
  real kg;

  always #5 clk = ~clk;

  cordic_rotate_iter #(
    .WIDTH(16),
    .ITERS(N),
    .GUARD(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .angle_in(angle_in),
    .mag_in(mag_in),
    .busy(busy),
    .done(done),
    .cos_out(cos_out),
    .sin_out(sin_out)
  );

  typedef struct {
    string       nm;
    logic [15:0] a;
    int          m;
    int          ec;
    int          es;
    int          tol;
  } vec_t;

  // mag*trig(angle) times (CORDIC gain * shift-add compensation), clamped
  function automatic int model(input logic [15:0] a, input int m,
                               input bit want_sin);
    real th, v;
    int  r;
    th = 2.0 * PI * real'(a) / 65536.0;
    v  = real'(m) * kg * (want_sin ? $sin(th) : $cos(th));
    r  = $rtoi(v + ((v >= 0.0) ? 0.5 : -0.5));
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp,
                     input int tol);
    int d;
    d = act - exp;
    if (d < 0) d = -d;
    n_chk++;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)",
               nm, act, exp, tol);
    end
  endtask

  task automatic run(input logic [15:0] a, input int m,
                     output int c, output int s,
                     output int lat, output int bc);
    @(negedge clk);
    angle_in = a;
    mag_in   = 16'(m);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    bc    = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) bc++;
    end
    c = int'($signed(cos_out));
    s = int'($signed(sin_out));
  endtask

  vec_t vecs[$];

  initial begin
    int   c, s, lat, bc, nd, first, second, bsy, dn, m;
    logic [15:0] a;
    real  p;

    kg = 0.607421875;
    p  = 1.0;
    for (int i = 0; i < N; i++) begin
      kg = kg * $sqrt(1.0 + p);
      p  = p / 4.0;
    end

    vecs.push_back('{"q90",   16'h4000,  16384, 0, 0, TOLS});
    vecs.push_back('{"q270",  16'hC000,  16384, 0, 0, TOLS});
    vecs.push_back('{"q180",  16'h8000,  16384, 0, 0, TOLS});
    vecs.push_back('{"d45",   16'h2000,  32767, 0, 0, TOLL});
    vecs.push_back('{"dm45",  16'hE000,  32767, 0, 0, TOLL});
    vecs.push_back('{"neg0",  16'h0000, -32768, 0, 0, TOLL});
    vecs.push_back('{"neg180",16'h8000, -32768, 0, 0, TOLL});
    vecs.push_back('{"a6000", 16'h6000, -12000, 0, 0, TOLS});
    vecs.push_back('{"a1234", 16'h1234,   5000, 0, 0, TOLS});
    foreach (vecs[k]) begin
      vecs[k].ec = model(vecs[k].a, vecs[k].m, 1'b0);
      vecs[k].es = model(vecs[k].a, vecs[k].m, 1'b1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0, 0);
    chk("rst_done", int'(done), 0, 0);
    chk("rst_cos", int'($signed(cos_out)), 0, 0);
    chk("rst_sin", int'($signed(sin_out)), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run(16'h0000, 16384, c, s, lat, bc);
    chk("first_lat", lat, 15, 0);
    chk("first_busy", bc, 15, 0);
    chk("first_cos", c, model(16'h0000, 16384, 1'b0), TOLS);
    chk("first_sin", s, model(16'h0000, 16384, 1'b1), TOLS);

    foreach (vecs[k]) begin
      run(vecs[k].a, vecs[k].m, c, s, lat, bc);
      chk({vecs[k].nm, "_lat"}, lat, 15, 0);
      chk({vecs[k].nm, "_cos"}, c, vecs[k].ec, vecs[k].tol);
      chk({vecs[k].nm, "_sin"}, s, vecs[k].es, vecs[k].tol);
    end

    // second start pulse during the run must be dropped
    @(negedge clk);
    angle_in = 16'h3000;
    mag_in   = 16'(12000);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    nd    = 0;
    first = -1;
    for (int k = 1; k <= 30; k++) begin
      if (k == 5) start = 1'b1;
      @(posedge clk);
      #1;
      if (k == 5) start = 1'b0;
      if (done) begin
        nd++;
        if (first < 0) first = k;
      end
    end
    chk("ign_ndone", nd, 1, 0);
    chk("ign_lat", first, 15, 0);
    chk("ign_cos", int'($signed(cos_out)),
        model(16'h3000, 12000, 1'b0), TOLS);
    chk("ign_sin", int'($signed(sin_out)),
        model(16'h3000, 12000, 1'b1), TOLS);

    // start held through done: second run starts with no gap
    @(negedge clk);
    angle_in = 16'h5000;
    mag_in   = 16'(9000);
    start    = 1'b1;
    @(posedge clk);
    #1;
    first  = -1;
    second = -1;
    bsy    = 0;
    dn     = 1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (first >= 0 && k == first + 1) begin
        bsy   = int'(busy);
        dn    = int'(done);
        start = 1'b0;
      end
      if (done && first < 0) begin
        first = k;
        c = int'($signed(cos_out));
        s = int'($signed(sin_out));
        angle_in = 16'h9000;
        mag_in   = 16'(-7000);
      end else if (done && second < 0) begin
        second = k;
      end
    end
    start = 1'b0;
    chk("b2b_first", first, 15, 0);
    chk("b2b_cos1", c, model(16'h5000, 9000, 1'b0), TOLS);
    chk("b2b_sin1", s, model(16'h5000, 9000, 1'b1), TOLS);
    chk("b2b_busy", bsy, 1, 0);
    chk("b2b_pulse", dn, 0, 0);
    chk("b2b_gap", second - first, 16, 0);
    chk("b2b_cos2", int'($signed(cos_out)),
        model(16'h9000, -7000, 1'b0), TOLS);
    chk("b2b_sin2", int'($signed(sin_out)),
        model(16'h9000, -7000, 1'b1), TOLS);

    // reset in the middle of a run
    @(negedge clk);
    angle_in = 16'h1000;
    mag_in   = 16'(10000);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", int'(busy), 0, 0);
    chk("mrst_done", int'(done), 0, 0);
    chk("mrst_cos", int'($signed(cos_out)), 0, 0);
    chk("mrst_sin", int'($signed(sin_out)), 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    chk("mrst_nodone", nd, 0, 0);
    run(16'h1000, 10000, c, s, lat, bc);
    chk("mrst_lat", lat, 15, 0);
    chk("mrst_cos2", c, model(16'h1000, 10000, 1'b0), TOLS);
    chk("mrst_sin2", s, model(16'h1000, 10000, 1'b1), TOLS);

    // random vectors against the real-valued model
    for (int k = 0; k < 40; k++) begin
      a = 16'($urandom);
      if (k % 2 == 0) m = int'($urandom_range(0, 32768)) - 16384;
      else            m = int'($urandom_range(0, 65535)) - 32768;
      run(a, m, c, s, lat, bc);
      chk("rnd_lat", lat, 15, 0);
      chk("rnd_cos", c, model(a, m, 1'b0),
          (m >= -16384 && m <= 16384) ? TOLS : TOLL);
      chk("rnd_sin", s, model(a, m, 1'b1),
          (m >= -16384 && m <= 16384) ? TOLS : TOLL);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
